// File: rtl/uart_send_sequencer.sv
// Sequences a CPU send instruction into LSB-first bytes for a UART transmitter,
// using a start/busy handshake and stalling the CPU until the last byte has left.
module uart_send_sequencer #(
  parameter logic [5:0] OPCODE_SND    = 6'b010001,
  parameter int         NBYTES        = 4,
  parameter bit         REQUIRE_RCV   = 1'b1,
  parameter int         START_TIMEOUT = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [31:0] send_data,
  input  logic       rcv_done,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_byte,
  output logic       cpu_stall,
  output logic       snd_done,
  output logic       snd_skip,
  output logic       snd_err,
  output logic [2:0] dbg_state
);

  // Handshake: tx_start is a one-cycle load strobe while tx_byte is stable; the
  // transmitter answers by raising tx_busy, and the byte is complete when it falls.
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;

  localparam int TW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT + 1) : 1;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [2:0]    state;
  logic [31:0]   shift_reg;
  logic [IW-1:0] byte_idx;
  logic [TW-1:0] tmo_cnt;
  logic [TW-1:0] tmo_next;
  logic          match_d;
  logic          armed;
  logic          match;
  logic          req;
  logic          accept;
  logic          skip_req;

  always_comb begin
    match     = (opcode == OPCODE_SND);
    req       = match & ~match_d;
    accept    = (state == S_IDLE) & req & armed;
    skip_req  = (state == S_IDLE) & req & ~armed;
    cpu_stall = accept | (state != S_IDLE);
    dbg_state = state;
    // Saturating so a long wait can never wrap back below the abort threshold.
    tmo_next  = (tmo_cnt == TW'(START_TIMEOUT)) ? tmo_cnt : tmo_cnt + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      shift_reg <= '0;
      byte_idx  <= '0;
      tmo_cnt   <= '0;
      match_d   <= 1'b0;
      armed     <= ~REQUIRE_RCV;
      tx_start  <= 1'b0;
      tx_byte   <= '0;
      snd_done  <= 1'b0;
      snd_skip  <= 1'b0;
      snd_err   <= 1'b0;
    end else begin
      match_d  <= match;
      tx_start <= 1'b0;
      snd_done <= 1'b0;
      snd_skip <= 1'b0;
      snd_err  <= 1'b0;

      // A receive completing in the accept cycle re-arms the following send.
      if (rcv_done || !REQUIRE_RCV) begin
        armed <= 1'b1;
      end else if (accept) begin
        armed <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (accept) begin
            shift_reg <= send_data;
            byte_idx  <= '0;
            state     <= S_LOAD;
          end else if (skip_req) begin
            snd_skip <= 1'b1;
          end
        end
        S_LOAD: begin
          if (!tx_busy) begin
            tx_byte  <= shift_reg[7:0];
            tx_start <= 1'b1;
            tmo_cnt  <= '0;
            state    <= S_WAIT_BUSY;
          end
        end
        S_WAIT_BUSY: begin
          if (tx_busy) begin
            state <= S_WAIT_DONE;
          end else begin
            tmo_cnt <= tmo_next;
            if (tmo_next == TW'(START_TIMEOUT)) begin
              snd_err <= 1'b1;
              state   <= S_IDLE;
            end
          end
        end
        S_WAIT_DONE: begin
          if (!tx_busy) begin
            shift_reg <= shift_reg >> 8;
            byte_idx  <= byte_idx + 1'b1;
            if (byte_idx == IW'(NBYTES - 1)) begin
              snd_done <= 1'b1;
              state    <= S_DONE;
            end else begin
              state <= S_LOAD;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
